hazard_stall_ctrl: RTL and testbench

- Stall/bubble controller for the 5-stage pipeline.
- Sits directly downstream of the decode-stage source-use helpers, which produce the reads_rs/reads_rt flags for the instruction in D.
- Combines those flags with X-stage state to detect load-use hazards.
- Sequences the multi-cycle multdiv unit.
- Drives PC/F-D hold, D/X bubble and X/M bubble controls.

---
 rtl/hazard_stall_ctrl.sv | 127 ++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Load-use and multdiv stall/bubble controller for the 5-stage pipeline.
// Optional macro HAZARD_STALL_COUNT_EN adds a saturating stall_cycles counter.
module hazard_stall_ctrl #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 7
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       d_reads_rs,
  input  logic       d_reads_rt,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic       x_valid,
  input  logic [4:0] x_opcode,
  input  logic [4:0] x_aluop,
  input  logic [4:0] x_rd,
  input  logic       md_ready,
  output logic       stall_fd,
  output logic       stall_dx,
  output logic       bubble_dx,
  output logic       bubble_xm,
  output logic       md_start,
  output logic       md_busy,
  output logic       md_timeout
`ifdef HAZARD_STALL_COUNT_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  localparam logic [4:0]       OP_LW    = 5'b01000;
  localparam logic [4:0]       OP_RTYPE = 5'b00000;
  localparam logic [4:0]       ALU_MUL  = 5'b00110;
  localparam logic [4:0]       ALU_DIV  = 5'b00111;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);

  typedef enum logic {IDLE, MD_WAIT} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             x_lw;
  logic             x_md;
  logic             lu;
  logic             cnt_last;

  assign x_lw     = x_valid && (x_opcode == OP_LW);
  assign x_md     = x_valid && (x_opcode == OP_RTYPE) &&
                    ((x_aluop == ALU_MUL) || (x_aluop == ALU_DIV));
  assign lu       = (state == IDLE) && x_lw && (x_rd != 5'd0) &&
                    ((d_reads_rs && (d_rs == x_rd)) || (d_reads_rt && (d_rt == x_rd)));
  assign cnt_last = (cnt == CNT_LAST);

  // Controls are combinational so a hazard stalls in the cycle it appears.
  always_comb begin
    stall_fd   = 1'b0;
    stall_dx   = 1'b0;
    bubble_dx  = 1'b0;
    bubble_xm  = 1'b0;
    md_start   = 1'b0;
    md_busy    = 1'b0;
    md_timeout = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (x_md) begin
            md_start  = 1'b1;
            stall_fd  = 1'b1;
            stall_dx  = 1'b1;
            bubble_xm = 1'b1;
          end else if (lu) begin
            stall_fd  = 1'b1;
            bubble_dx = 1'b1;
          end
        end
        MD_WAIT: begin
          md_busy = 1'b1;
          // A ready result wins over a coincident timeout.
          if (!md_ready) begin
            if (cnt_last) begin
              md_timeout = 1'b1;
            end else begin
              stall_fd  = 1'b1;
              stall_dx  = 1'b1;
              bubble_xm = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (x_md) begin
            state <= MD_WAIT;
            cnt   <= '0;
          end
        end
        MD_WAIT: begin
          if (md_ready || cnt_last) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef HAZARD_STALL_COUNT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (stall_fd && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: vector table plus multi-cycle multdiv sequences.
module tb_hazard_stall_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       d_reads_rs, d_reads_rt;
  logic [4:0] d_rs, d_rt;
  logic       x_valid;
  logic [4:0] x_opcode, x_aluop, x_rd;
  logic       md_ready;
  logic       stall_fd, stall_dx, bubble_dx, bubble_xm, md_start, md_busy, md_timeout;
`ifdef HAZARD_STALL_COUNT_EN
  logic [31:0] stall_cycles;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  hazard_stall_ctrl #(.MD_TIMEOUT(64), .CNT_W(7)) dut (
    .clock      (clock),
    .reset      (reset),
    .d_reads_rs (d_reads_rs),
    .d_reads_rt (d_reads_rt),
    .d_rs       (d_rs),
    .d_rt       (d_rt),
    .x_valid    (x_valid),
    .x_opcode   (x_opcode),
    .x_aluop    (x_aluop),
    .x_rd       (x_rd),
    .md_ready   (md_ready),
    .stall_fd   (stall_fd),
    .stall_dx   (stall_dx),
    .bubble_dx  (bubble_dx),
    .bubble_xm  (bubble_xm),
    .md_start   (md_start),
    .md_busy    (md_busy),
    .md_timeout (md_timeout)
`ifdef HAZARD_STALL_COUNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clock = ~clock;

  // Expected vector bit order: {stall_fd, stall_dx, bubble_dx, bubble_xm, md_start, md_busy, md_timeout}
  localparam logic [6:0] E_NONE  = 7'b0000000;
  localparam logic [6:0] E_LU    = 7'b1010000;
  localparam logic [6:0] E_START = 7'b1101100;
  localparam logic [6:0] E_WAIT  = 7'b1101010;
  localparam logic [6:0] E_REL   = 7'b0000010;
  localparam logic [6:0] E_TOUT  = 7'b0000011;

  localparam logic [4:0] OP_LW  = 5'b01000;
  localparam logic [4:0] OP_R   = 5'b00000;
  localparam logic [4:0] AL_MUL = 5'b00110;
  localparam logic [4:0] AL_DIV = 5'b00111;

  typedef struct {
    logic       rrs;
    logic       rrt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       xv;
    logic [4:0] op;
    logic [4:0] alu;
    logic [4:0] rd;
    logic       rdy;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[14];

  task automatic set_in(input logic rrs, input logic rrt, input logic [4:0] rs,
                        input logic [4:0] rt, input logic xv, input logic [4:0] op,
                        input logic [4:0] alu, input logic [4:0] rd, input logic rdy);
    reset      = 1'b0;
    d_reads_rs = rrs;
    d_reads_rt = rrt;
    d_rs       = rs;
    d_rt       = rt;
    x_valid    = xv;
    x_opcode   = op;
    x_aluop    = alu;
    x_rd       = rd;
    md_ready   = rdy;
  endtask

  task automatic set_nop(input logic rdy);
    set_in(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, rdy);
  endtask

  task automatic check(input string nm, input int idx, input logic [6:0] exp);
    logic [6:0] got;
    got = {stall_fd, stall_dx, bubble_dx, bubble_xm, md_start, md_busy, md_timeout};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %b expected %b", nm, idx, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    set_nop(1'b0);
    reset = 1'b1;
    #1 check("reset", 0, E_NONE);
  endtask

  // Mul/div issued in X, held for 'waits' stalled cycles, then released by md_ready.
  task automatic md_seq(input logic [4:0] alu, input int waits, input string nm);
    @(negedge clock);
    set_in(1'b0, 1'b0, 5'd0, 5'd0, 1'b1, OP_R, alu, 5'd9, 1'b0);
    #1 check({nm, "_start"}, 0, E_START);
    for (int i = 0; i < waits; i++) begin
      @(negedge clock);
      if (i == 5) begin
        // A load-use pattern while busy must not add a D/X bubble.
        set_in(1'b1, 1'b0, 5'd5, 5'd0, 1'b1, OP_LW, 5'd0, 5'd5, 1'b0);
      end else begin
        set_in(1'b0, 1'b0, 5'd0, 5'd0, 1'b1, OP_R, alu, 5'd9, 1'b0);
      end
      #1 check({nm, "_wait"}, i, E_WAIT);
    end
    @(negedge clock);
    set_in(1'b0, 1'b0, 5'd0, 5'd0, 1'b1, OP_R, alu, 5'd9, 1'b1);
    #1 check({nm, "_ready"}, 0, E_REL);
  endtask

  initial begin
    //               rrs   rrt   rs     rt     xv    op     alu      rd     rdy   exp
    vecs[0]  = '{1'b1, 1'b0, 5'd5, 5'd0, 1'b1, OP_LW, 5'd0,    5'd5, 1'b0, E_LU};
    vecs[1]  = '{1'b1, 1'b1, 5'd3, 5'd5, 1'b1, OP_LW, 5'd0,    5'd5, 1'b0, E_LU};
    vecs[2]  = '{1'b1, 1'b1, 5'd0, 5'd0, 1'b1, OP_LW, 5'd0,    5'd0, 1'b0, E_NONE};
    vecs[3]  = '{1'b0, 1'b0, 5'd5, 5'd5, 1'b1, OP_LW, 5'd0,    5'd5, 1'b0, E_NONE};
    vecs[4]  = '{1'b1, 1'b1, 5'd5, 5'd5, 1'b0, OP_LW, 5'd0,    5'd5, 1'b0, E_NONE};
    vecs[5]  = '{1'b1, 1'b1, 5'd6, 5'd4, 1'b1, OP_LW, 5'd0,    5'd5, 1'b0, E_NONE};
    vecs[6]  = '{1'b0, 1'b0, 5'd0, 5'd0, 1'b1, OP_R,  AL_MUL,  5'd7, 1'b0, E_START};
    vecs[7]  = '{1'b1, 1'b0, 5'd7, 5'd0, 1'b1, OP_R,  AL_DIV,  5'd7, 1'b0, E_START};
    vecs[8]  = '{1'b1, 1'b0, 5'd5, 5'd0, 1'b1, OP_R,  5'b00101, 5'd5, 1'b0, E_NONE};
    vecs[9]  = '{1'b0, 1'b0, 5'd0, 5'd0, 1'b0, OP_R,  AL_MUL,  5'd7, 1'b0, E_NONE};
    vecs[10] = '{1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0,  5'd0,    5'd0, 1'b1, E_NONE};
    vecs[11] = '{1'b0, 1'b1, 5'd5, 5'd5, 1'b1, OP_LW, 5'd0,    5'd5, 1'b0, E_LU};
    vecs[12] = '{1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 5'b00001, AL_MUL, 5'd7, 1'b0, E_NONE};
    vecs[13] = '{1'b1, 1'b0, 5'd5, 5'd0, 1'b1, OP_LW, 5'd0,    5'd6, 1'b1, E_NONE};

    set_nop(1'b0);
    reset = 1'b1;

    for (int v = 0; v < 14; v++) begin
      do_reset();
      @(negedge clock);
      set_in(vecs[v].rrs, vecs[v].rrt, vecs[v].rs, vecs[v].rt, vecs[v].xv,
             vecs[v].op, vecs[v].alu, vecs[v].rd, vecs[v].rdy);
      #1 check("vec", v, vecs[v].exp);
    end

    // Load-use stall lasts exactly one cycle once X moves on.
    do_reset();
    @(negedge clock);
    set_in(1'b1, 1'b0, 5'd5, 5'd0, 1'b1, OP_LW, 5'd0, 5'd5, 1'b0);
    #1 check("lu_stall", 0, E_LU);
    @(negedge clock);
    set_in(1'b1, 1'b0, 5'd5, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    #1 check("lu_after", 0, E_NONE);

    // Mul with 17 wait cycles, then back-to-back div with a fresh start pulse.
    do_reset();
    md_seq(AL_MUL, 17, "mul");
    md_seq(AL_DIV, 3, "b2b");
    @(negedge clock);
    set_nop(1'b0);
    #1 check("b2b_idle", 0, E_NONE);

    // Div never completes: forced release on the 64th wait cycle.
    do_reset();
    @(negedge clock);
    set_in(1'b0, 1'b0, 5'd0, 5'd0, 1'b1, OP_R, AL_DIV, 5'd9, 1'b0);
    #1 check("to_start", 0, E_START);
    for (int i = 0; i < 63; i++) begin
      @(negedge clock);
      #1 check("to_wait", i, E_WAIT);
    end
    @(negedge clock);
    #1 check("to_pulse", 0, E_TOUT);
    @(negedge clock);
    set_nop(1'b0);
    #1 check("to_idle", 0, E_NONE);

    // Ready coincident with the timeout cycle counts as ready.
    do_reset();
    @(negedge clock);
    set_in(1'b0, 1'b0, 5'd0, 5'd0, 1'b1, OP_R, AL_MUL, 5'd9, 1'b0);
    #1 check("rt_start", 0, E_START);
    for (int i = 0; i < 63; i++) begin
      @(negedge clock);
      #1;
    end
    check("rt_wait63", 0, E_WAIT);
    @(negedge clock);
    md_ready = 1'b1;
    #1 check("rt_both", 0, E_REL);

    // Reset at wait cycle 10 abandons the op; a late md_ready is ignored.
    do_reset();
    @(negedge clock);
    set_in(1'b0, 1'b0, 5'd0, 5'd0, 1'b1, OP_R, AL_MUL, 5'd9, 1'b0);
    #1 check("rst_start", 0, E_START);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      #1 check("rst_wait", i, E_WAIT);
    end
    @(negedge clock);
    reset = 1'b1;
    #1 check("rst_mid", 0, E_NONE);
    @(negedge clock);
    set_nop(1'b1);
    #1 check("rst_late_rdy", 0, E_NONE);
    @(negedge clock);
    set_nop(1'b0);
    #1 check("rst_idle", 0, E_NONE);

`ifdef HAZARD_STALL_COUNT_EN
    do_reset();
    @(negedge clock);
    set_nop(1'b0);
    #1;
    n_cmp++;
    if (stall_cycles !== 32'd0) begin
      n_bad++;
      $display("FAIL cnt_reset: got %0d expected 0", stall_cycles);
    end
    set_in(1'b1, 1'b0, 5'd5, 5'd0, 1'b1, OP_LW, 5'd0, 5'd5, 1'b0);
    #1 check("cnt_lu", 0, E_LU);
    @(negedge clock);
    set_nop(1'b0);
    md_seq(AL_MUL, 17, "cnt_mul");
    @(negedge clock);
    set_nop(1'b0);
    #1;
    n_cmp++;
    if (stall_cycles !== 32'd19) begin
      n_bad++;
      $display("FAIL cnt_total: got %0d expected 19", stall_cycles);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
